// File: rtl/urna_pkg.sv
// Shared state encodings, BCD blank code and helpers for the voting core.
package urna_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_BLANK = 4'hF;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ENTRY    = 3'd1;
  localparam logic [2:0] ST_CONFIRM  = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_WINNER   = 3'd4;
  localparam logic [2:0] ST_APURACAO = 3'd5;
  localparam logic [2:0] ST_CAND     = 3'd6;
  localparam logic [2:0] ST_TOTAIS   = 3'd7;

  // Two-digit decimal number to packed {tens, units} BCD.
  function automatic logic [7:0] num2bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction
endpackage

// File: rtl/urna_bcd2_counter.sv
// Two-digit BCD incrementer that saturates at 99.
module urna_bcd2_counter
  import urna_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       inc,
  output bcd_digit_t dez,
  output bcd_digit_t uni
);
  bcd_digit_t dez_q, dez_d, uni_q, uni_d;

  always_comb begin
    dez_d = dez_q;
    uni_d = uni_q;
    if (inc && !(dez_q == 4'd9 && uni_q == 4'd9)) begin
      if (uni_q == 4'd9) begin
        uni_d = 4'd0;
        dez_d = dez_q + 4'd1;
      end else begin
        uni_d = uni_q + 4'd1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dez_q <= 4'd0;
      uni_q <= 4'd0;
    end else begin
      dez_q <= dez_d;
      uni_q <= uni_d;
    end
  end

  assign dez = dez_q;
  assign uni = uni_q;
endmodule

// File: rtl/urna_vote_tally.sv
// Voting core FSM: keypad entry, BCD tallies, results screens and winner.
// Define URNA_BLANK_VOTE_EN to accept a confirm with no digits as a blank vote.
module urna_vote_tally
  import urna_pkg::*;
#(
  parameter int CAND1_NUM   = 12,
  parameter int CAND2_NUM   = 13,
  parameter int CAND3_NUM   = 17,
  parameter int CAND4_NUM   = 45,
  parameter int DONE_CYCLES = 50000000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iDigitValid,
  input  logic [3:0] iDigit,
  input  logic       iConfirm,
  input  logic       iCancel,
  input  logic       iEndVoting,
  output logic [2:0] oEstado,
  output logic [3:0] oBcd2,
  output logic [3:0] oBcd1,
  output logic [3:0] oC1Dez,
  output logic [3:0] oC1Uni,
  output logic [3:0] oC2Dez,
  output logic [3:0] oC2Uni,
  output logic [3:0] oC3Dez,
  output logic [3:0] oC3Uni,
  output logic [3:0] oC4Dez,
  output logic [3:0] oC4Uni,
  output logic [3:0] oNDez,
  output logic [3:0] oNUni,
  output logic [3:0] oTDez,
  output logic [3:0] oTUni,
  output logic [3:0] oCadVencedr1,
  output logic [3:0] oCadVencedr2,
  output logic       oRefresh
);
  localparam int TW       = $clog2(DONE_CYCLES + 1);
  localparam int NCNT     = 6;
  localparam int IDX_NULL = 4;
  localparam int IDX_TOT  = 5;
  localparam logic [TW-1:0] TLOAD = TW'(DONE_CYCLES - 1);
  localparam logic [3:0][7:0] CAND_BCD = {num2bcd(CAND4_NUM), num2bcd(CAND3_NUM),
                                          num2bcd(CAND2_NUM), num2bcd(CAND1_NUM)};

  logic [2:0]  state_q, state_d;
  bcd_digit_t  bcd2_q, bcd2_d, bcd1_q, bcd1_d, win1_q, win1_d, win2_q, win2_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        refresh_q, refresh_d;
  logic [NCNT-1:0]      inc;
  logic [NCNT-1:0][3:0] t_dez, t_uni;
  logic [7:0]  best_cnt, best_num;
  logic        hit;

  // Only the highest-priority strobe acts: cancel > confirm > digit > end.
  logic s_cancel, s_confirm, s_digit, s_end;
  assign s_cancel  = iCancel;
  assign s_confirm = iConfirm & ~iCancel;
  assign s_digit   = iDigitValid & ~iConfirm & ~iCancel & (iDigit <= 4'd9);
  assign s_end     = iEndVoting & ~iDigitValid & ~iConfirm & ~iCancel;

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    urna_bcd2_counter u_cnt (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .inc   (inc[g]),
      .dez   (t_dez[g]),
      .uni   (t_uni[g])
    );
  end

  // Strict compare from a zero floor: ties keep the lowest index, all-zero stays blank.
  always_comb begin
    best_cnt = 8'd0;
    best_num = {BCD_BLANK, BCD_BLANK};
    for (int i = 0; i < 4; i++) begin
      if ({t_dez[i], t_uni[i]} > best_cnt) begin
        best_cnt = {t_dez[i], t_uni[i]};
        best_num = CAND_BCD[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bcd2_d  = bcd2_q;
    bcd1_d  = bcd1_q;
    timer_d = timer_q;
    win1_d  = win1_q;
    win2_d  = win2_q;
    inc     = '0;
    hit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_confirm) begin
          state_d = ST_ENTRY;
          bcd2_d  = BCD_BLANK;
          bcd1_d  = BCD_BLANK;
        end else if (s_end) begin
          state_d          = ST_APURACAO;
          {win1_d, win2_d} = best_num;
        end
      end
      ST_ENTRY: begin
        if (s_cancel) begin
          bcd2_d = BCD_BLANK;
          bcd1_d = BCD_BLANK;
`ifdef URNA_BLANK_VOTE_EN
        end else if (s_confirm && bcd2_q == BCD_BLANK) begin
          inc[IDX_TOT] = 1'b1;
          state_d      = ST_DONE;
          timer_d      = TLOAD;
`endif
        end else if (s_digit) begin
          if (bcd2_q == BCD_BLANK) begin
            bcd2_d = iDigit;
          end else begin
            bcd1_d  = iDigit;
            state_d = ST_CONFIRM;
          end
        end
      end
      ST_CONFIRM: begin
        if (s_cancel) begin
          state_d = ST_ENTRY;
          bcd2_d  = BCD_BLANK;
          bcd1_d  = BCD_BLANK;
        end else if (s_confirm) begin
          for (int i = 0; i < 4; i++) begin
            if ({bcd2_q, bcd1_q} == CAND_BCD[i]) begin
              inc[i] = 1'b1;
              hit    = 1'b1;
            end
          end
          inc[IDX_NULL] = ~hit;
          inc[IDX_TOT]  = 1'b1;
          state_d       = ST_DONE;
          timer_d       = TLOAD;
        end
      end
      ST_DONE: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          bcd2_d  = BCD_BLANK;
          bcd1_d  = BCD_BLANK;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_APURACAO, ST_WINNER: if (s_confirm) state_d = ST_CAND;
      ST_CAND:                if (s_confirm) state_d = ST_TOTAIS;
      ST_TOTAIS:              if (s_confirm) state_d = ST_WINNER;
    endcase
    refresh_d = (state_d != state_q) | (bcd2_d != bcd2_q) | (bcd1_d != bcd1_q);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      bcd2_q    <= BCD_BLANK;
      bcd1_q    <= BCD_BLANK;
      win1_q    <= BCD_BLANK;
      win2_q    <= BCD_BLANK;
      timer_q   <= '0;
      refresh_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      bcd2_q    <= bcd2_d;
      bcd1_q    <= bcd1_d;
      win1_q    <= win1_d;
      win2_q    <= win2_d;
      timer_q   <= timer_d;
      refresh_q <= refresh_d;
    end
  end

  assign oEstado      = state_q;
  assign oBcd2        = bcd2_q;
  assign oBcd1        = bcd1_q;
  assign oCadVencedr1 = win1_q;
  assign oCadVencedr2 = win2_q;
  assign oRefresh     = refresh_q;
  assign {oC1Dez, oC1Uni} = {t_dez[0], t_uni[0]};
  assign {oC2Dez, oC2Uni} = {t_dez[1], t_uni[1]};
  assign {oC3Dez, oC3Uni} = {t_dez[2], t_uni[2]};
  assign {oC4Dez, oC4Uni} = {t_dez[3], t_uni[3]};
  assign {oNDez, oNUni}   = {t_dez[IDX_NULL], t_uni[IDX_NULL]};
  assign {oTDez, oTUni}   = {t_dez[IDX_TOT], t_uni[IDX_TOT]};
endmodule

// File: tb/tb_urna_vote_tally.sv
// Scoreboard bench for urna_vote_tally: votes push expected tallies, DONE screen pops them.
module tb_urna_vote_tally;
  localparam int D = 8;
  localparam int CNUM [4] = '{12, 13, 17, 45};

  logic iCLK = 1'b0, iRST_N = 1'b0;
  logic iDigitValid = 1'b0, iConfirm = 1'b0, iCancel = 1'b0, iEndVoting = 1'b0;
  logic [3:0] iDigit = 4'd0;
  logic [2:0] oEstado;
  logic [3:0] oBcd2, oBcd1, oC1Dez, oC1Uni, oC2Dez, oC2Uni, oC3Dez, oC3Uni;
  logic [3:0] oC4Dez, oC4Uni, oNDez, oNUni, oTDez, oTUni, oCadVencedr1, oCadVencedr2;
  logic       oRefresh;

  urna_vote_tally #(.DONE_CYCLES(D)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDigitValid(iDigitValid), .iDigit(iDigit),
    .iConfirm(iConfirm), .iCancel(iCancel), .iEndVoting(iEndVoting),
    .oEstado(oEstado), .oBcd2(oBcd2), .oBcd1(oBcd1),
    .oC1Dez(oC1Dez), .oC1Uni(oC1Uni), .oC2Dez(oC2Dez), .oC2Uni(oC2Uni),
    .oC3Dez(oC3Dez), .oC3Uni(oC3Uni), .oC4Dez(oC4Dez), .oC4Uni(oC4Uni),
    .oNDez(oNDez), .oNUni(oNUni), .oTDez(oTDez), .oTUni(oTUni),
    .oCadVencedr1(oCadVencedr1), .oCadVencedr2(oCadVencedr2), .oRefresh(oRefresh)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [3:0][7:0] c;
    logic [7:0]      n;
    logic [7:0]      t;
  } tally_t;

  tally_t sb_q[$];
  int m_c[4];
  int m_n, m_t;
  int n_chk = 0, n_fail = 0;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_tally(input string tag, input tally_t e);
    chk({tag, "_c1"}, {oC1Dez, oC1Uni}, e.c[0]);
    chk({tag, "_c2"}, {oC2Dez, oC2Uni}, e.c[1]);
    chk({tag, "_c3"}, {oC3Dez, oC3Uni}, e.c[2]);
    chk({tag, "_c4"}, {oC4Dez, oC4Uni}, e.c[3]);
    chk({tag, "_n"},  {oNDez, oNUni},   e.n);
    chk({tag, "_t"},  {oTDez, oTUni},   e.t);
  endtask

  function automatic tally_t model_tally();
    tally_t e;
    for (int i = 0; i < 4; i++) e.c[i] = bcd(m_c[i]);
    e.n = bcd(m_n);
    e.t = bcd(m_t);
    return e;
  endfunction

  task automatic strobe(input logic cf, input logic cn, input logic dv,
                        input logic [3:0] d, input logic ev);
    @(negedge iCLK);
    iConfirm = cf; iCancel = cn; iDigitValid = dv; iDigit = d; iEndVoting = ev;
    @(negedge iCLK);
    iConfirm = 1'b0; iCancel = 1'b0; iDigitValid = 1'b0; iEndVoting = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    for (int i = 0; i < 4; i++) m_c[i] = 0;
    m_n = 0;
    m_t = 0;
    sb_q.delete();
  endtask

  // Finishes a vote from the ENTRY screen through DONE and back to IDLE.
  task automatic vote(input int num, input bit in_entry);
    int cnt, hit;
    tally_t e;
    if (!in_entry) begin
      strobe(1, 0, 0, 0, 0);
      chk("v_s1", oEstado, 1);
      chk("v_s1_ref", oRefresh, 1);
      chk("v_s1_bcd2", oBcd2, 4'hF);
    end
    strobe(0, 0, 1, 4'(num / 10), 0);
    chk("v_d2", oBcd2, num / 10);
    chk("v_d2_ref", oRefresh, 1);
    strobe(0, 0, 1, 4'(num % 10), 0);
    chk("v_s2", oEstado, 2);
    chk("v_d1", oBcd1, num % 10);
    hit = -1;
    for (int i = 0; i < 4; i++) if (num == CNUM[i]) hit = i;
    if (hit >= 0) begin
      if (m_c[hit] < 99) m_c[hit]++;
    end else if (m_n < 99) m_n++;
    if (m_t < 99) m_t++;
    sb_q.push_back(model_tally());
    strobe(1, 0, 0, 0, 0);
    cnt = 0;
    while (oEstado != 3'd3 && cnt < 20) begin @(negedge iCLK); cnt++; end
    chk("v_s3", oEstado, 3);
    chk("v_s3_hold", oBcd2, num / 10);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_tally("v_tally", e);
    end
    cnt = 0;
    while (oEstado == 3'd3 && cnt < D + 20) begin @(negedge iCLK); cnt++; end
    chk("v_lat", cnt, D);
    chk("v_idle", oEstado, 0);
    chk("v_blank", {oBcd2, oBcd1}, 8'hFF);
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_ref", oRefresh, 1);
    chk("rst_st", oEstado, 0);
    chk("rst_bcd", {oBcd2, oBcd1}, 8'hFF);
    chk("rst_win", {oCadVencedr1, oCadVencedr2}, 8'hFF);
    chk_tally("rst", model_tally());
    @(negedge iCLK);
    chk("rst_ref0", oRefresh, 0);

    vote(13, 0);
    chk("v13_c2", {oC2Dez, oC2Uni}, 8'h01);

    // reset in the middle of an entry
    strobe(1, 0, 0, 0, 0);
    strobe(0, 0, 1, 4'd4, 0);
    do_reset();
    #1;
    chk("mid_st", oEstado, 0);
    chk("mid_bcd", oBcd2, 4'hF);
    chk_tally("mid", model_tally());

    vote(99, 0);

    // illegal digit, cancel, and cancel winning over confirm
    strobe(1, 0, 0, 0, 0);
    strobe(0, 0, 1, 4'd12, 0);
    chk("ill_bcd2", oBcd2, 4'hF);
    chk("ill_ref", oRefresh, 0);
    strobe(0, 0, 1, 4'd4, 0);
    strobe(0, 0, 1, 4'd5, 0);
    chk("cn_s2", oEstado, 2);
    strobe(0, 1, 0, 0, 0);
    chk("cn_s1", oEstado, 1);
    chk("cn_bcd", {oBcd2, oBcd1}, 8'hFF);
    strobe(0, 0, 1, 4'd4, 0);
    strobe(0, 0, 1, 4'd5, 0);
    strobe(1, 1, 0, 0, 0);
    chk("cc_s1", oEstado, 1);
    chk("cc_bcd", {oBcd2, oBcd1}, 8'hFF);
    chk_tally("cc", model_tally());
    vote(45, 1);

    // saturation
    do_reset();
    repeat (100) vote(17, 0);
    chk("sat_c3", {oC3Dez, oC3Uni}, 8'h99);
    chk("sat_t", {oTDez, oTUni}, 8'h99);

    // results screens with a tie between candidates 1 and 4
    do_reset();
    repeat (3) vote(12, 0);
    repeat (3) vote(45, 0);
    vote(13, 0);
    strobe(0, 0, 1, 4'd3, 1);
    chk("pri_idle", oEstado, 0);
    strobe(0, 0, 0, 0, 1);
    chk("res_s5", oEstado, 5);
    chk("res_ref5", oRefresh, 1);
    chk("res_win", {oCadVencedr1, oCadVencedr2}, 8'h12);
    @(negedge iCLK);
    chk("res_ref_idle", oRefresh, 0);
    strobe(1, 0, 0, 0, 0);
    chk("res_s6", oEstado, 6);
    chk("res_ref6", oRefresh, 1);
    strobe(1, 0, 0, 0, 0);
    chk("res_s7", oEstado, 7);
    strobe(1, 0, 0, 0, 0);
    chk("res_s4", oEstado, 4);
    chk("res_ref4", oRefresh, 1);
    strobe(1, 0, 0, 0, 0);
    chk("res_s6b", oEstado, 6);
    strobe(0, 0, 0, 0, 1);
    chk("res_end_ign", oEstado, 6);
    strobe(0, 0, 1, 4'd3, 0);
    chk("res_dig_ign", oEstado, 6);
    chk("res_ref_ign", oRefresh, 0);

    // no votes -> blank winner
    do_reset();
    strobe(0, 0, 0, 0, 1);
    chk("nw_s5", oEstado, 5);
    chk("nw_win", {oCadVencedr1, oCadVencedr2}, 8'hFF);

    // confirm with no digits entered
    do_reset();
    strobe(1, 0, 0, 0, 0);
    strobe(1, 0, 0, 0, 0);
`ifdef URNA_BLANK_VOTE_EN
    m_t = 1;
    chk("blk_s3", oEstado, 3);
    chk("blk_bcd", {oBcd2, oBcd1}, 8'hFF);
    chk_tally("blk", model_tally());
`else
    chk("blk_s1", oEstado, 1);
    chk_tally("blk", model_tally());
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
